serial_to_parallel: RTL and testbench

- Deserializer: collects single-bit samples qualified by a valid strobe and packs each group of `width` accepted bits into one parallel word.
- Emits that word with a one-cycle valid pulse.
- Sits between a serial bit source (line receiver, bit-level decoder) and word-oriented downstream logic.
- No backpressure: every completed word is presented exactly once.

---
 rtl/serial_to_parallel.sv | 59 +++++
 tb/tb_serial_to_parallel.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel.sv
// Deserializer: packs each group of `width` accepted serial bits into one registered word
// with a one-cycle valid pulse. Define S2P_MSB_FIRST_EN for MSB-first packing (default LSB first).
module serial_to_parallel #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_valid,
  input  logic             serial_data,
  output logic             parallel_valid,
  output logic [width-1:0] parallel_data
);

  localparam int unsigned CW = (width > 2) ? $clog2(width) : 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  logic [CW-1:0]    r_cnt;
  logic [width-1:0] r_shift;
  logic [width-1:0] w_shift_next;
  logic             w_last;

  // After `width` shifts the first accepted bit sits at the far end of the register.
`ifdef S2P_MSB_FIRST_EN
  always_comb begin
    w_shift_next = {r_shift[width-2:0], serial_data};
  end
`else
  always_comb begin
    w_shift_next = {serial_data, r_shift[width-1:1]};
  end
`endif

  always_comb begin
    w_last = serial_valid && (r_cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (serial_valid) begin
      r_shift <= w_shift_next;
      r_cnt   <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parallel_valid <= 1'b0;
      parallel_data  <= '0;
    end else begin
      parallel_valid <= w_last;
      if (w_last) begin
        parallel_data <= w_shift_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed + table-driven bench for serial_to_parallel (width=8); honours S2P_MSB_FIRST_EN.
module tb_serial_to_parallel;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_valid = 1'b0;
  logic       serial_data = 1'b0;
  logic       parallel_valid;
  logic [7:0] parallel_data;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic       rst_n;
    logic       v;
    logic       d;
    logic       exp_pv;
    logic [7:0] exp_pd;
  } vec_t;

  vec_t vecs[$];
  logic ref_bits[$];

  serial_to_parallel #(.width(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_valid   (serial_valid),
    .serial_data    (serial_data),
    .parallel_valid (parallel_valid),
    .parallel_data  (parallel_data)
  );

  always #5 clk = ~clk;

  // Bit k (in send order) of a word, according to the packing order under test.
  function automatic logic bit_of(input logic [7:0] w, input int unsigned k);
`ifdef S2P_MSB_FIRST_EN
    return w[7-k];
`else
    return w[k];
`endif
  endfunction

  function automatic int unsigned pos_of(input int unsigned k);
`ifdef S2P_MSB_FIRST_EN
    return 7 - k;
`else
    return k;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic v, input logic d, input logic pv, input logic [7:0] pd);
    vecs.push_back('{rst_n: r, v: v, d: d, exp_pv: pv, exp_pd: pd});
  endtask

  task automatic step(input logic v, input logic d);
    @(negedge clk);
    serial_valid = v;
    serial_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] words[3];
    logic [7:0] prev;
    logic [7:0] w;
    int unsigned pulses;
    int unsigned accepted;
    int unsigned got;

    // Vector table: reset, alternating word, three back-to-back words.
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int unsigned k = 0; k < 8; k++)
      add(1'b1, 1'b1, bit_of(8'h55, k), (k == 7), (k == 7) ? 8'h55 : 8'h00);
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'h55);
    words[0] = 8'h0F; words[1] = 8'hF0; words[2] = 8'h3C;
    prev = 8'h55;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned k = 0; k < 8; k++)
        add(1'b1, 1'b1, bit_of(words[i], k), (k == 7), (k == 7) ? words[i] : prev);
      prev = words[i];
    end
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'h3C);

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst          = vecs[i].rst_n;
      serial_valid = vecs[i].v;
      serial_data  = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), 64'(parallel_valid), 64'(vecs[i].exp_pv));
      check($sformatf("vec%0d_data", i), 64'(parallel_data), 64'(vecs[i].exp_pd));
    end

    // Gapped A5: invalid cycles carry random data that must be ignored.
    for (int unsigned k = 0; k < 8; k++) begin
      int unsigned gaps;
      gaps = $urandom_range(0, 3);
      for (int unsigned g = 0; g < gaps; g++) begin
        step(1'b0, 1'($urandom_range(0, 1)));
        check("gap_no_pulse", 64'(parallel_valid), 64'd0);
      end
      step(1'b1, bit_of(8'hA5, k));
      check("gap_valid", 64'(parallel_valid), 64'(k == 7));
    end
    check("gap_data", 64'(parallel_data), 64'hA5);
    step(1'b0, 1'b0);
    check("gap_single_pulse", 64'(parallel_valid), 64'd0);

    // Random soak: 800 accepted bits checked against an accept-order reference queue.
    pulses = 0;
    accepted = 0;
    while (accepted < 800 || ref_bits.size() != 0) begin
      logic v, d;
      v = (accepted < 800) ? ($urandom_range(0, 9) < 7) : 1'b0;
      d = 1'($urandom_range(0, 1));
      if (v) begin
        ref_bits.push_back(d);
        accepted++;
      end
      step(v, d);
      if (parallel_valid) begin
        pulses++;
        if (ref_bits.size() < 8) begin
          check("soak_extra_pulse", 64'(ref_bits.size()), 64'd8);
        end else begin
          w = '0;
          for (int unsigned k = 0; k < 8; k++) w[pos_of(k)] = ref_bits.pop_front();
          check("soak_word", 64'(parallel_data), 64'(w));
        end
      end
      if (accepted >= 800 && ref_bits.size() != 0 && ref_bits.size() < 8) begin
        check("soak_leftover", 64'(ref_bits.size()), 64'd0);
        ref_bits.delete();
      end
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("soak_no_late_pulse", 64'(parallel_valid), 64'd0);
    check("soak_pulse_count", 64'(pulses), 64'd100);
    check("soak_conservation", 64'(pulses * 8), 64'(accepted));

    // Mid-word reset: 5 bits discarded, then C3 forms a clean word.
    for (int unsigned k = 0; k < 5; k++) begin
      step(1'b1, 1'($urandom_range(0, 1)));
      check("mid_partial_no_pulse", 64'(parallel_valid), 64'd0);
    end
    @(negedge clk);
    serial_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_async_valid", 64'(parallel_valid), 64'd0);
    check("mid_async_data", 64'(parallel_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    got = 0;
    for (int unsigned k = 0; k < 8; k++) begin
      step(1'b1, bit_of(8'hC3, k));
      if (parallel_valid) got++;
      check("mid_valid", 64'(parallel_valid), 64'(k == 7));
    end
    check("mid_data", 64'(parallel_data), 64'hC3);
    step(1'b0, 1'b0);
    check("mid_after", 64'(parallel_valid), 64'd0);
    check("mid_pulse_count", 64'(got), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "timeout");
  end

endmodule
